shake256_digest_drain: RTL
==========================

// Module: shake256_digest_drain
// PURPOSE
//  Output end of the SHAKE256 pipeline. Captures each 256-bit digest on the pipeline's
//  single-cycle done pulse into a DEPTH-entry buffer. Streams each digest out as DATA_W-bit
//  beats on a valid/ready interface. The pipeline cannot stall, so the block issues credits:
//  upstream may pulse the pipeline enable only while can_issue=1.
// PARAMETERS
//  DATA_W  32  output beat width; must divide 256 (8, 16, 32, 64, 128, 256)
//  DEPTH   4   digest buffer entries; power of two, >=2
// PORTS
//  clk        in   1       clock, rising edge
//  rstn       in   1       synchronous active-low reset
//  issue      in   1       same pulse as the pipeline enable; one block enters the pipeline
//  done       in   1       pipeline result strobe, 1 cycle per digest
//  hash       in   256     pipeline digest, valid while done=1
//  can_issue  out  1       credit available; upstream must not pulse issue while 0
//  m_data     out  DATA_W  output beat
//  m_valid    out  1       beat valid
//  m_last     out  1       final beat of a digest
//  m_ready    in   1       sink accepts the beat
//  overflow   out  1       sticky: a digest was dropped
//  ovf_cnt    out  16      dropped-digest count (see CONFIGURATION)
// BEHAVIOUR
//  Reset (rstn=0 at posedge): pointers, occupancy, inflight, beat counter, overflow and
//   ovf_cnt are cleared. m_valid=0, m_last=0, m_data=0. can_issue=0 while rstn=0.
//  Buffer: occupancy cnt in 0..DEPTH. Pointers are log2(DEPTH)+1 bits, wrap modulo 2*DEPTH.
//   full = (cnt==DEPTH). empty = (cnt==0).
//  Push: done=1 with not full, or full with a pop in the same cycle -> hash is written.
//   Push while full with no pop -> digest is dropped, overflow<=1, ovf_cnt++.
//  Latency: done in cycle t -> m_valid=1 in cycle t+1, carrying beat 0 of that digest.
//  Serialise: NB = 256/DATA_W beats per digest. The beat index b is a register.
//   m_data = head[255-b*DATA_W -: DATA_W], MSB first, so beat 0 = hash[255:256-DATA_W].
//   m_valid = !empty. m_last = m_valid && (b==NB-1).
//  Handshake: a beat transfers when m_valid && m_ready. Then b <= b+1.
//   On the last beat: b <= 0 and the head entry is popped.
//   When m_ready=0, m_data and m_last hold stable. m_valid never drops before the transfer.
//  Credit: inflight counts blocks inside the pipeline. issue increments it, done decrements it.
//   issue and done in the same cycle leave it unchanged. done with inflight==0 leaves it at 0.
//   can_issue = rstn && (cnt + inflight < DEPTH), combinational from registers.
//   A pop in the current cycle does not raise can_issue until the next cycle.
//  Protocol violation: issue while can_issue=0 is still counted. inflight saturates at 2*DEPTH-1.
//   Any resulting drop is reported through overflow/ovf_cnt only.
//  Overflow is cleared only by reset.
//  Reset mid-stream: the partial digest is discarded. No further beat of it is presented.
//  DATA_W=256: NB=1, m_last=m_valid.
// CONFIGURATION
//  SHAKE_DRAIN_OVF_CNT_EN defined: ovf_cnt is a 16-bit counter, saturating at 16'hFFFF.
//  Not defined: no counter register; ovf_cnt is tied to 16'h0. overflow remains as specified.
// STRUCTURE
//  Package shake_pkg: DIGEST_W=256, RATE_W=1088, STATE_W=1600, and an NB derivation function.
//   The pipeline blocks use the same package.
//  Sub-module digest_fifo: synchronous DEPTH x 256 FIFO with push, pop, full, empty, cnt and
//   head outputs, with write-when-full-and-pop allowed.
//  The top level holds the beat counter, the credit counter and the overflow logic.
// TESTING
//  1 Reset, then one done with hash=256'h0123..CDEF and m_ready=1 -> 8 beats (DATA_W=32).
//    First beat 32'h01234567, m_last on beat 8, then m_valid=0.
//  2 m_ready toggling 1010 pattern -> m_data and m_last stable while stalled.
//    Digest order preserved over 3 back-to-back digests.
//  3 m_ready=0, 4 issues, then 4 dones -> can_issue goes 0 after the 4th issue.
//    cnt=4, overflow=0. can_issue returns 1 the cycle after the first pop.
//  4 Full buffer, m_ready=0, forced 5th done -> digest dropped, overflow=1,
//    ovf_cnt=1 (0 without the macro). The stored 4 digests drain intact.
//  5 Full buffer, done coincident with a last-beat pop -> digest accepted, no overflow.
//  6 rstn=0 during beat 3 of 8 -> m_valid=0 next cycle, cnt=0, can_issue=1 after release.

Source files
------------

// File: rtl/shake_pkg.sv
// Shared SHAKE256 widths and the digest beat-count helper.
// Used by the pipeline stages and by the digest drain.
package shake_pkg;

    localparam int DIGEST_W = 256;
    localparam int RATE_W   = 1088;
    localparam int STATE_W  = 1600;

    // Beats needed to stream one digest at the given beat width.
    function automatic int calc_nb(input int data_w);
        return DIGEST_W / data_w;
    endfunction

endpackage

// File: rtl/digest_fifo.sv
// Purpose: DEPTH x 256 synchronous digest buffer, head always presented.
// Latency: a pushed entry is visible at head (empty=0) the cycle after the push.
// Backpressure: none internally; a push while full is only legal alongside a pop.
module digest_fifo
    import shake_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      push,
    input  logic                      pop,
    input  logic [DIGEST_W-1:0]       din,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    cnt,
    output logic [DIGEST_W-1:0]       head
);

    localparam int AW = $clog2(DEPTH);

    logic [DIGEST_W-1:0] r_mem [DEPTH];
    logic [AW:0]         r_wptr;
    logic [AW:0]         r_rptr;
    logic [AW:0]         r_cnt;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (push) r_wptr <= r_wptr + (AW+1)'(1);
            if (pop)  r_rptr <= r_rptr + (AW+1)'(1);
            case ({push, pop})
                2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
                2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) r_mem[r_wptr[AW-1:0]] <= din;
    end

    assign head  = r_mem[r_rptr[AW-1:0]];
    assign cnt   = r_cnt;
    assign full  = (r_cnt == (AW+1)'(DEPTH));
    assign empty = (r_cnt == '0);

endmodule

// File: rtl/shake256_digest_drain.sv
// Purpose: buffers SHAKE256 digests and streams them MSB-first as DATA_W beats; issues pipeline credits.
// Latency: done in cycle t -> beat 0 valid in t+1. Backpressure: m_ready stalls the stream; full buffer drops.
// Option: SHAKE_DRAIN_OVF_CNT_EN adds a saturating 16-bit dropped-digest counter on ovf_cnt.
module shake256_digest_drain
    import shake_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                issue,
    input  logic                done,
    input  logic [255:0]        hash,
    output logic                can_issue,
    output logic [DATA_W-1:0]   m_data,
    output logic                m_valid,
    output logic                m_last,
    input  logic                m_ready,
    output logic                overflow,
    output logic [15:0]         ovf_cnt
);

    localparam int NB = calc_nb(DATA_W);
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;
    localparam int AW = $clog2(DEPTH);
    localparam int SW = AW + 2;
    localparam logic [AW:0] INF_MAX = (AW+1)'(2*DEPTH - 1);

    logic                w_full;
    logic                w_empty;
    logic [AW:0]         w_cnt;
    logic [DIGEST_W-1:0] w_head;
    logic [DIGEST_W-1:0] w_shifted;
    logic                w_last_beat;
    logic                w_xfer;
    logic                w_pop;
    logic                w_push;
    logic                w_drop;
    logic [SW-1:0]       w_sum;

    logic [BW-1:0]       r_b;
    logic [AW:0]         r_inflight;
    logic                r_overflow;

    digest_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (w_push),
        .pop   (w_pop),
        .din   (hash),
        .full  (w_full),
        .empty (w_empty),
        .cnt   (w_cnt),
        .head  (w_head)
    );

    assign w_last_beat = (r_b == BW'(NB - 1));
    assign w_xfer      = m_valid && m_ready;
    assign w_pop       = w_xfer && w_last_beat;
    // A last-beat pop frees a slot in the same cycle, so a full buffer can still accept.
    assign w_push      = done && (!w_full || w_pop);
    assign w_drop      = done && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_b <= '0;
        end else if (w_xfer) begin
            r_b <= w_last_beat ? '0 : r_b + BW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_inflight <= '0;
        end else if (issue && !done) begin
            if (r_inflight != INF_MAX) r_inflight <= r_inflight + (AW+1)'(1);
        end else if (done && !issue && (r_inflight != '0)) begin
            r_inflight <= r_inflight - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

`ifdef SHAKE_DRAIN_OVF_CNT_EN
    logic [15:0] r_ovf_cnt;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_ovf_cnt <= '0;
        end else if (w_drop && (r_ovf_cnt != 16'hFFFF)) begin
            r_ovf_cnt <= r_ovf_cnt + 16'd1;
        end
    end

    assign ovf_cnt = r_ovf_cnt;
`else
    assign ovf_cnt = 16'h0;
`endif

    assign w_shifted = w_head << (32'(r_b) * DATA_W);
    assign m_valid   = !w_empty;
    assign m_data    = m_valid ? w_shifted[DIGEST_W-1 -: DATA_W] : '0;
    assign m_last    = m_valid && w_last_beat;
    assign overflow  = r_overflow;

    // Credits come from registered state only, so a pop shows up one cycle later.
    assign w_sum     = SW'(w_cnt) + SW'(r_inflight);
    assign can_issue = rstn && (w_sum < SW'(DEPTH));

endmodule
